// File: rtl/t07_fpu_wb_pkg.sv
// Shared types for the FPU writeback slice: the queued result entry and the FP register count.
package t07_fpu_wb_pkg;
  localparam int FP_REGS = 32;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/t07_fpu_wb_fifo.sv
// Two-write/one-read result FIFO. Port wr0 is accepted ahead of wr1 when both are valid.
// A pop in the same edge frees one slot for the incoming writes.
module t07_fpu_wb_fifo
  import t07_fpu_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            wr0_valid,
  input  wb_entry_t       wr0_entry,
  input  logic            wr1_valid,
  input  wb_entry_t       wr1_entry,
  input  logic            pop,
  output wb_entry_t       head,
  output logic [PTR_W:0]  count,
  output logic            drop0,
  output logic            drop1
);
  localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);

  wb_entry_t        mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] wr1_ptr;
  logic [PTR_W:0]   count_reg, count_next;
  logic [PTR_W+1:0] space, space1;
  logic             pop_eff, acc0, acc1;

  always_comb begin
    pop_eff     = pop & (count_reg != '0);
    space       = DEPTH_W - {1'b0, count_reg} + (PTR_W+2)'(pop_eff);
    acc0        = wr0_valid & (space != '0);
    space1      = space - (PTR_W+2)'(acc0);
    acc1        = wr1_valid & (space1 != '0);
    wr1_ptr     = wr_ptr_reg + PTR_W'(acc0);
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop_eff);
    wr_ptr_next = wr_ptr_reg + PTR_W'(acc0) + PTR_W'(acc1);
    count_next  = count_reg + (PTR_W+1)'(acc0) + (PTR_W+1)'(acc1) - (PTR_W+1)'(pop_eff);
    drop0       = wr0_valid & ~acc0;
    drop1       = wr1_valid & ~acc1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset; the head is qualified by count in the top.
  always_ff @(posedge clk) begin
    if (acc0) mem_reg[wr_ptr_reg] <= wr0_entry;
    if (acc1) mem_reg[wr1_ptr]    <= wr1_entry;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/t07_fpu_writeback.sv
// FPU register-file write producer: result FIFO, busy scoreboard and decode hazard detect.
// Optional operand bypass from the popping head is enabled by T07_FPU_WB_BYPASS_EN.
module t07_fpu_writeback
  import t07_fpu_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        freeze_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        fpu_valid_i,
  input  logic [4:0]  fpu_rd_i,
  input  logic [31:0] fpu_data_i,
  input  logic        load_valid_i,
  input  logic [4:0]  load_rd_i,
  input  logic [31:0] load_data_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        ready_o,
  output logic [4:0]  rd_o,
  output logic [31:0] data_o,
  output logic        FPUregWrite_o,
  output logic        regEnable_o,
  output logic        hazard_o,
  output logic        overflow_o
`ifdef T07_FPU_WB_BYPASS_EN
  ,
  output logic        byp1_o,
  output logic        byp2_o,
  output logic [31:0] byp_data_o
`endif
);
  wb_entry_t            load_entry, fpu_entry, head;
  logic [PTR_W:0]       count;
  logic                 nonempty, pop, drop0, drop1;
  logic                 load_wr, fpu_wr;
  logic                 overflow_reg;
  logic [FP_REGS-1:0]   busy_reg, busy_next;
  logic                 byp1, byp2;

  assign load_entry = '{rd: load_rd_i, data: load_data_i};
  assign fpu_entry  = '{rd: fpu_rd_i,  data: fpu_data_i};
  assign load_wr    = load_valid_i & (load_rd_i != 5'd0);
  assign fpu_wr     = fpu_valid_i  & (fpu_rd_i  != 5'd0);

  t07_fpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .wr0_valid (load_wr),
    .wr0_entry (load_entry),
    .wr1_valid (fpu_wr),
    .wr1_entry (fpu_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .drop0     (drop0),
    .drop1     (drop1)
  );

  assign nonempty      = (count != '0);
  assign pop           = nonempty & ~freeze_i;
  assign ready_o       = (count <= (PTR_W+1)'(DEPTH-2));
  assign rd_o          = nonempty ? head.rd   : 5'd0;
  assign data_o        = nonempty ? head.data : 32'd0;
  assign FPUregWrite_o = nonempty;
  assign regEnable_o   = nonempty;
  assign overflow_o    = overflow_reg;

  // A same-edge issue to the popping index keeps it busy: the set dominates the clear.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < FP_REGS; gi++) begin : g_busy
      assign busy_next[gi] = (issue_valid_i && (issue_rd_i == 5'(gi))) |
                             (busy_reg[gi] & ~(pop && (head.rd == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      busy_reg     <= busy_next;
      overflow_reg <= overflow_reg | drop0 | drop1;
    end
  end

`ifdef T07_FPU_WB_BYPASS_EN
  assign byp1       = pop & (head.rd == rs1_i) & (rs1_i != 5'd0);
  assign byp2       = pop & (head.rd == rs2_i) & (rs2_i != 5'd0);
  assign byp1_o     = byp1;
  assign byp2_o     = byp2;
  assign byp_data_o = data_o;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // The WAW term is never bypassed: the older write still has to land first.
  assign hazard_o = (busy_reg[rs1_i] & ~byp1) |
                    (busy_reg[rs2_i] & ~byp2) |
                    (issue_valid_i & busy_reg[issue_rd_i]);
endmodule

// File: tb/tb_t07_fpu_writeback.sv
// Bench for t07_fpu_writeback: directed vector table, async-reset and freeze sequences,
// then randomized traffic against a queue-based reference model.
module tb_t07_fpu_writeback;
  localparam int DEPTH = 4;

  logic        clk, nrst, freeze_i, issue_valid_i, fpu_valid_i, load_valid_i;
  logic [4:0]  issue_rd_i, fpu_rd_i, load_rd_i, rs1_i, rs2_i;
  logic [31:0] fpu_data_i, load_data_i;
  logic        ready_o, FPUregWrite_o, regEnable_o, hazard_o, overflow_o;
  logic [4:0]  rd_o;
  logic [31:0] data_o;
`ifdef T07_FPU_WB_BYPASS_EN
  logic        byp1_o, byp2_o;
  logic [31:0] byp_data_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  t07_fpu_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .freeze_i(freeze_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .fpu_valid_i(fpu_valid_i), .fpu_rd_i(fpu_rd_i), .fpu_data_i(fpu_data_i),
    .load_valid_i(load_valid_i), .load_rd_i(load_rd_i), .load_data_i(load_data_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .ready_o(ready_o), .rd_o(rd_o), .data_o(data_o),
    .FPUregWrite_o(FPUregWrite_o), .regEnable_o(regEnable_o),
    .hazard_o(hazard_o), .overflow_o(overflow_o)
`ifdef T07_FPU_WB_BYPASS_EN
    , .byp1_o(byp1_o), .byp2_o(byp2_o), .byp_data_o(byp_data_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic frz, iv; logic [4:0] ird;
    logic fv; logic [4:0] frd; logic [31:0] fd;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic [4:0] rs1, rs2;
    logic e_ready; logic [4:0] e_rd; logic [31:0] e_data;
    logic e_wr, e_haz, e_ovf;
  } vec_t;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

  ent_t        mq[$];
  logic [31:0] mbusy;
  logic        movf;

  function automatic vec_t mk(input logic frz, iv, input logic [4:0] ird,
                              input logic fv, input logic [4:0] frd, input logic [31:0] fd,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic [4:0] rs1, rs2,
                              input logic e_ready, input logic [4:0] e_rd, input logic [31:0] e_data,
                              input logic e_wr, e_haz, e_ovf);
    vec_t v;
    v.frz = frz; v.iv = iv; v.ird = ird; v.fv = fv; v.frd = frd; v.fd = fd;
    v.lv = lv; v.lrd = lrd; v.ld = ld; v.rs1 = rs1; v.rs2 = rs2;
    v.e_ready = e_ready; v.e_rd = e_rd; v.e_data = e_data;
    v.e_wr = e_wr; v.e_haz = e_haz; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    freeze_i = v.frz; issue_valid_i = v.iv; issue_rd_i = v.ird;
    fpu_valid_i = v.fv; fpu_rd_i = v.frd; fpu_data_i = v.fd;
    load_valid_i = v.lv; load_rd_i = v.lrd; load_data_i = v.ld;
    rs1_i = v.rs1; rs2_i = v.rs2;
  endtask

  task automatic idle();
    apply(mk(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    mq.delete();
    mbusy = '0;
    movf  = 1'b0;
  endtask

  // Expected outputs for the current inputs, from the queue/bit-array model state.
  task automatic model_check(input int cyc);
    logic ne, pop, e_byp1, e_byp2;
    ne     = (mq.size() > 0);
    pop    = ne && !freeze_i;
    e_byp1 = 1'b0;
    e_byp2 = 1'b0;
`ifdef T07_FPU_WB_BYPASS_EN
    e_byp1 = pop && (mq[0].rd == rs1_i) && (rs1_i != 0);
    e_byp2 = pop && (mq[0].rd == rs2_i) && (rs2_i != 0);
    chk($sformatf("rnd%0d.byp1", cyc), 32'(byp1_o), 32'(e_byp1));
    chk($sformatf("rnd%0d.byp2", cyc), 32'(byp2_o), 32'(e_byp2));
    if (e_byp1 || e_byp2) chk($sformatf("rnd%0d.bypdata", cyc), byp_data_o, mq[0].data);
`endif
    chk($sformatf("rnd%0d.rd", cyc),    32'(rd_o),   ne ? 32'(mq[0].rd) : 32'd0);
    chk($sformatf("rnd%0d.data", cyc),  data_o,      ne ? mq[0].data : 32'd0);
    chk($sformatf("rnd%0d.wr", cyc),    32'(FPUregWrite_o), 32'(ne));
    chk($sformatf("rnd%0d.en", cyc),    32'(regEnable_o),   32'(ne));
    chk($sformatf("rnd%0d.ready", cyc), 32'(ready_o),  32'(mq.size() <= DEPTH-2));
    chk($sformatf("rnd%0d.ovf", cyc),   32'(overflow_o), 32'(movf));
    chk($sformatf("rnd%0d.haz", cyc),   32'(hazard_o),
        32'((mbusy[rs1_i] && !e_byp1) || (mbusy[rs2_i] && !e_byp2) ||
            (issue_valid_i && mbusy[issue_rd_i])));
    $display("rnd %0d: n=%0d frz=%0b rd=%0d wr=%0b haz=%0b ovf=%0b",
             cyc, mq.size(), freeze_i, rd_o, FPUregWrite_o, hazard_o, overflow_o);
  endtask

  // Edge effect: pop first (frees a slot), load before FPU, clear then set busy.
  task automatic model_step();
    logic [4:0] prd;
    logic       pop;
    pop = (mq.size() > 0) && !freeze_i;
    prd = pop ? mq[0].rd : 5'd0;
    if (pop) void'(mq.pop_front());
    if (load_valid_i && load_rd_i != 0) begin
      if (mq.size() < DEPTH) mq.push_back('{rd: load_rd_i, data: load_data_i});
      else movf = 1'b1;
    end
    if (fpu_valid_i && fpu_rd_i != 0) begin
      if (mq.size() < DEPTH) mq.push_back('{rd: fpu_rd_i, data: fpu_data_i});
      else movf = 1'b1;
    end
    if (pop && prd != 0) mbusy[prd] = 1'b0;
    if (issue_valid_i && issue_rd_i != 0) mbusy[issue_rd_i] = 1'b1;
  endtask

  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(0,1,5,  0,0,0,             0,0,0,             5,0, 1,0,0,            0,0,0);
    tbl[1]  = mk(0,0,0,  1,5,32'h3F800000,  0,0,0,             5,0, 1,0,0,            0,1,0);
    tbl[2]  = mk(0,0,0,  0,0,0,             0,0,0,             5,0, 1,5,32'h3F800000, 1,1,0);
    tbl[3]  = mk(0,0,0,  1,3,32'h40400000,  1,2,32'h40000000,  5,0, 1,0,0,            0,0,0);
    tbl[4]  = mk(0,0,0,  0,0,0,             0,0,0,             0,0, 1,2,32'h40000000, 1,0,0);
    tbl[5]  = mk(0,1,7,  0,0,0,             0,0,0,             0,0, 1,3,32'h40400000, 1,0,0);
    tbl[6]  = mk(0,0,0,  1,7,32'h12345678,  0,0,0,             7,0, 1,0,0,            0,1,0);
    tbl[7]  = mk(1,0,0,  0,0,0,             0,0,0,             7,0, 1,7,32'h12345678, 1,1,0);
    tbl[8]  = mk(1,0,0,  0,0,0,             0,0,0,             7,0, 1,7,32'h12345678, 1,1,0);
    tbl[9]  = mk(1,0,0,  0,0,0,             0,0,0,             7,0, 1,7,32'h12345678, 1,1,0);
    tbl[10] = mk(0,0,0,  0,0,0,             0,0,0,             7,0, 1,7,32'h12345678, 1,1,0);
    tbl[11] = mk(0,0,0,  1,0,32'h0000DEAD,  1,0,32'h0000BEEF,  7,0, 1,0,0,            0,0,0);
    tbl[12] = mk(1,0,0,  1,11,32'hB,        1,10,32'hA,        0,0, 1,0,0,            0,0,0);
    tbl[13] = mk(1,0,0,  0,0,0,             1,12,32'hC,        0,0, 1,10,32'hA,       1,0,0);
    tbl[14] = mk(1,0,0,  1,13,32'hD,        0,0,0,             0,0, 0,10,32'hA,       1,0,0);
    tbl[15] = mk(1,0,0,  1,14,32'hE,        0,0,0,             0,0, 0,10,32'hA,       1,0,0);
    tbl[16] = mk(1,1,4,  0,0,0,             0,0,0,             0,0, 0,10,32'hA,       1,0,1);
    tbl[17] = mk(1,1,4,  0,0,0,             0,0,0,             0,0, 0,10,32'hA,       1,1,1);
    tbl[18] = mk(0,0,0,  1,15,32'hF,        1,16,32'h10,       0,0, 0,10,32'hA,       1,0,1);
    tbl[19] = mk(1,0,0,  0,0,0,             0,0,0,             0,0, 0,11,32'hB,       1,0,1);

    nrst = 1'b0;
    idle();
    #3;
    chk("rst.wr",    32'(FPUregWrite_o), 32'd0);
    chk("rst.en",    32'(regEnable_o),   32'd0);
    chk("rst.rd",    32'(rd_o),          32'd0);
    chk("rst.data",  data_o,             32'd0);
    chk("rst.ready", 32'(ready_o),       32'd1);
    chk("rst.haz",   32'(hazard_o),      32'd0);
    chk("rst.ovf",   32'(overflow_o),    32'd0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d.ready", i), 32'(ready_o),       32'(tbl[i].e_ready));
      chk($sformatf("v%0d.rd", i),    32'(rd_o),          32'(tbl[i].e_rd));
      chk($sformatf("v%0d.data", i),  data_o,             tbl[i].e_data);
      chk($sformatf("v%0d.wr", i),    32'(FPUregWrite_o), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d.en", i),    32'(regEnable_o),   32'(tbl[i].e_wr));
      chk($sformatf("v%0d.haz", i),   32'(hazard_o),      32'(tbl[i].e_haz));
      chk($sformatf("v%0d.ovf", i),   32'(overflow_o),    32'(tbl[i].e_ovf));
      $display("vec %0d: rd=%0d data=%0h wr=%0b ready=%0b haz=%0b ovf=%0b",
               i, rd_o, data_o, FPUregWrite_o, ready_o, hazard_o, overflow_o);
    end

    // Pop one (queue 11,12,13,16 -> 12,13,16), then async reset mid-cycle with 3 queued.
    @(negedge clk);
    idle();
    @(negedge clk);
    freeze_i = 1'b1;
    rs1_i    = 5'd4;
    #1;
    chk("mid.wr_before", 32'(FPUregWrite_o), 32'd1);
    chk("mid.rd_before", 32'(rd_o),          32'd12);
    chk("mid.haz_before", 32'(hazard_o),     32'd1);
    #1;
    nrst = 1'b0;
    #1;
    chk("mid.wr",    32'(FPUregWrite_o), 32'd0);
    chk("mid.rd",    32'(rd_o),          32'd0);
    chk("mid.data",  data_o,             32'd0);
    chk("mid.ready", 32'(ready_o),       32'd1);
    chk("mid.ovf",   32'(overflow_o),    32'd0);
    chk("mid.haz",   32'(hazard_o),      32'd0);
    $display("async reset: wr=%0b ready=%0b haz=%0b ovf=%0b", FPUregWrite_o, ready_o, hazard_o, overflow_o);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    #1;
    chk("post.wr",  32'(FPUregWrite_o), 32'd0);
    chk("post.haz", 32'(hazard_o),      32'd0);

`ifdef T07_FPU_WB_BYPASS_EN
    @(negedge clk);
    idle();
    issue_valid_i = 1'b1; issue_rd_i = 5'd9;
    @(negedge clk);
    idle();
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd9; fpu_data_i = 32'hC0DE0009;
    @(negedge clk);
    idle();
    freeze_i = 1'b1; rs2_i = 5'd9;
    #1;
    chk("byp.frz_byp2", 32'(byp2_o),   32'd0);
    chk("byp.frz_haz",  32'(hazard_o), 32'd1);
    @(negedge clk);
    freeze_i = 1'b0;
    #1;
    chk("byp.byp2",  32'(byp2_o),   32'd1);
    chk("byp.byp1",  32'(byp1_o),   32'd0);
    chk("byp.data",  byp_data_o,    32'hC0DE0009);
    chk("byp.haz",   32'(hazard_o), 32'd0);
    $display("bypass: byp2=%0b data=%0h haz=%0b", byp2_o, byp_data_o, hazard_o);
    @(negedge clk);
    #1;
    chk("byp.after_haz", 32'(hazard_o), 32'd0);
    chk("byp.after_wr",  32'(FPUregWrite_o), 32'd0);
`endif

    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      freeze_i      = ($urandom_range(0, 9) < 3);
      issue_valid_i = ($urandom_range(0, 9) < 4);
      issue_rd_i    = 5'($urandom_range(0, 7));
      fpu_valid_i   = ($urandom_range(0, 9) < 4);
      fpu_rd_i      = 5'($urandom_range(0, 7));
      fpu_data_i    = $urandom;
      load_valid_i  = ($urandom_range(0, 9) < 4);
      load_rd_i     = 5'($urandom_range(0, 7));
      load_data_i   = $urandom;
      rs1_i         = 5'($urandom_range(0, 7));
      rs2_i         = 5'($urandom_range(0, 7));
      #1;
      model_check(c);
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/t07_fpu_writeback.md
Name: t07_fpu_writeback

Overview:
- Producer side of the FPU register file write port.
- Collects results from the multi-cycle FPU datapath and from FLW loads in a small FIFO.
- Drains one result per unfrozen cycle into the register file's rd/data/FPUregWrite/regEnable inputs.
- Keeps a 32-entry busy scoreboard so decode can stall on RAW/WAW hazards against pending FP destinations.

Parameters:
- DEPTH, 4, result FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- freeze_i  in  1  pipeline freeze; blocks FIFO pop
- issue_valid_i  in  1  an FP-destination instruction issues this cycle
- issue_rd_i  in  5  destination of the issuing instruction
- fpu_valid_i  in  1  FPU result valid
- fpu_rd_i  in  5  FPU result destination
- fpu_data_i  in  32  FPU result
- load_valid_i  in  1  FLW load data valid
- load_rd_i  in  5  load destination
- load_data_i  in  32  load data
- rs1_i, rs2_i  in  5 each  decode source operands for hazard check
- ready_o  out  1  FIFO can accept two results next edge
- rd_o  out  5  register file write index
- data_o  out  32  register file write data
- FPUregWrite_o  out  1  register file write strobe
- regEnable_o  out  1  register file enable
- hazard_o  out  1  decode must stall
- overflow_o  out  1  sticky: a result was dropped

Behaviour:
- Reset (async, nrst low): FIFO empty, all busy bits clear, overflow_o=0. Outputs are then rd_o=0, data_o=0, FPUregWrite_o=0, regEnable_o=0, hazard_o=0, ready_o=1.
- ready_o = (count <= DEPTH-2). Combinational from registered count.
- Enqueue:
  - Up to two results per edge. When both valid the same cycle, the load is written before the FPU result.
  - Results with rd=0 are discarded and never stored.
  - A valid result presented while count would exceed DEPTH is dropped and sets overflow_o. overflow_o clears only on reset.
- Dequeue:
  - While count>0: rd_o/data_o come from the head entry; FPUregWrite_o=1 and regEnable_o=1.
  - The head pops on the edge when freeze_i=0.
  - While freeze_i=1, outputs hold and nothing pops.
  - Empty: FPUregWrite_o=0, regEnable_o=0, rd_o=0, data_o=0.
  - Write-through latency: a result enqueued at edge N is the head at N if the FIFO was empty, and is written at N+1 if unfrozen.
- Simultaneous push and pop are legal at any count, including full. Count changes by pushes minus pop.
- Scoreboard:
  - issue_valid_i with issue_rd_i!=0 sets busy[issue_rd_i].
  - A pop clears busy[head rd]. If the same edge sets that index, the set wins.
  - busy[0] is always 0.
- hazard_o = busy[rs1_i] | busy[rs2_i] | (issue_valid_i & busy[issue_rd_i]).
  - The last term is the WAW stall.
  - Registered busy state is used, so a result popped at edge N stops causing a stall from cycle N onward.
- Pointers wrap modulo DEPTH. Count is PTR_W+1 bits.

Optional Feature:
- Macro: T07_FPU_WB_BYPASS_EN.
- When defined:
  - Adds outputs byp1_o, byp2_o (1 bit each) and byp_data_o (32).
  - In a cycle where the head will pop (count>0, freeze_i=0) and head rd equals rs1_i/rs2_i (nonzero), the matching byp*_o=1 and byp_data_o=head data.
  - That operand's busy term is masked from hazard_o.
- When undefined: the ports do not exist and hazard_o is as above.

Decomposition:
- Package t07_fpu_wb_pkg holds:
  - typedef wb_entry_t (packed struct: rd 5, data 32);
  - localparam FP_REGS=32.
- One sub-module, t07_fpu_wb_fifo: 2-write/1-read FIFO of wb_entry_t with count output.
- Scoreboard and hazard logic stay in the top.

Test Plan:
- Reset: nrst low mid-stream with 3 entries queued -> FIFO empty, all busy 0, FPUregWrite_o=0 immediately (async), ready_o=1.
- Single path: issue rd=5, then fpu_valid rd=5 data=0x3F800000 -> next cycle rd_o=5, data_o=0x3F800000, FPUregWrite_o=1. hazard_o for rs1=5 is 1 until the pop edge, 0 after.
- Dual push: load rd=2 data=0x40000000 and fpu rd=3 data=0x40400000 in the same cycle -> writes rd=2 then rd=3 on consecutive unfrozen cycles.
- Freeze: head rd=7 with freeze_i=1 for 3 cycles -> outputs held for 3 cycles, single write after release, busy[7] cleared only then.
- Boundaries:
  - rd=0 results leave count unchanged.
  - Filling to DEPTH=4 with no pop, then one more push, sets overflow_o=1.
  - ready_o=0 at count 3.
  - Issue rd=4 while busy[4]=1 gives hazard_o=1.
- Bypass (macro defined): head rd=9 popping with rs2_i=9 -> byp2_o=1, byp_data_o=head data, hazard_o=0.
